// File: rtl/data_pack_pkg.sv
// Shared widths, FSM states and output-word payload for the 7->32 packer.
package data_pack_pkg;

    localparam int unsigned IN_W    = 7;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned ACC_W   = 45;
    localparam int unsigned CNT_W   = 6;
    // Highest fill level that still leaves room for one more value.
    localparam int unsigned RDY_MAX = ACC_W - IN_W;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sop;
        logic             eop;
    } word_t;

endpackage

// File: rtl/data_pack_if.sv
// Stream bus of the packer: 7-bit values in, framed 32-bit words out.
// err_out exists only when DATA_PACK_ERR_EN is defined.
interface data_pack_if;
    import data_pack_pkg::*;

    logic             valid_in;
    logic             ready_out;
    logic [IN_W-1:0]  data_in;
    logic             sop_in;
    logic             eop_in;
    logic             valid_out;
    logic             ready_in;
    logic [OUT_W-1:0] data_out;
    logic             sop_out;
    logic             eop_out;
`ifdef DATA_PACK_ERR_EN
    logic             err_out;

    modport slave (
        input  valid_in, data_in, sop_in, eop_in, ready_in,
        output ready_out, valid_out, data_out, sop_out, eop_out, err_out
    );
    modport master (
        output valid_in, data_in, sop_in, eop_in, ready_in,
        input  ready_out, valid_out, data_out, sop_out, eop_out, err_out
    );
`else
    modport slave (
        input  valid_in, data_in, sop_in, eop_in, ready_in,
        output ready_out, valid_out, data_out, sop_out, eop_out
    );
    modport master (
        output valid_in, data_in, sop_in, eop_in, ready_in,
        input  ready_out, valid_out, data_out, sop_out, eop_out
    );
`endif

endinterface

// File: rtl/data_pack_datapath.sv
// Accumulator, bit count and output word register with normal/final move logic.
module data_pack_datapath
    import data_pack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             start,
    input  logic             flush,
    input  logic             ready_in,
    input  logic [IN_W-1:0]  data_in,
    output logic             valid_out,
    output logic [OUT_W-1:0] data_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic [CNT_W-1:0] cnt_next_c,
    output logic             final_c
);

    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] VAL_BITS  = CNT_W'(IN_W);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             sop_pend;
    logic             sop_pend_next;
    logic             free;
    logic             move_norm;
    word_t            word_q;

    assign free      = !valid_out || ready_in;
    // The final word may be exactly full; it still carries eop.
    assign final_c   = flush && (cnt != '0) && (cnt <= WORD_BITS) && free;
    assign move_norm = (cnt >= WORD_BITS) && free && !final_c;

    always_comb begin
        acc_next      = acc;
        cnt_next_c    = cnt;
        sop_pend_next = sop_pend;
        if (final_c) begin
            acc_next   = '0;
            cnt_next_c = '0;
        end else if (move_norm) begin
            acc_next   = acc >> OUT_W;
            cnt_next_c = cnt - WORD_BITS;
        end
        if (move_norm || final_c) begin
            sop_pend_next = 1'b0;
        end
        if (start) begin
            sop_pend_next = 1'b1;
        end
        // Upper bits are zero, so OR-ing at the post-move count places the value.
        if (wr) begin
            acc_next   = acc_next | (ACC_W'(data_in) << cnt_next_c);
            cnt_next_c = cnt_next_c + VAL_BITS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sop_pend  <= 1'b0;
            valid_out <= 1'b0;
            word_q    <= '0;
        end else begin
            acc      <= acc_next;
            cnt      <= cnt_next_c;
            sop_pend <= sop_pend_next;
            if (move_norm || final_c) begin
                valid_out   <= 1'b1;
                word_q.data <= acc[OUT_W-1:0];
                word_q.sop  <= sop_pend;
                word_q.eop  <= final_c;
            end else if (ready_in) begin
                valid_out  <= 1'b0;
                word_q.sop <= 1'b0;
                word_q.eop <= 1'b0;
            end
        end
    end

    assign data_out = word_q.data;
    assign sop_out  = word_q.sop;
    assign eop_out  = word_q.eop;

endmodule

// File: rtl/data_pack.sv
// 7->32 LSB-first packer top: packet FSM, registered ready_out, datapath instance.
// Optional err_out pulse when DATA_PACK_ERR_EN is defined.
module data_pack
    import data_pack_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    data_pack_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             wr;
    logic             start;
    logic             flush;
    logic             final_c;
    logic             ready_next;
    logic [CNT_W-1:0] cnt_next_c;

    assign accept = bus.valid_in && bus.ready_out;
    assign flush  = (state == FLUSH);

    always_comb begin
        state_next = state;
        wr         = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && bus.sop_in) begin
                    wr         = 1'b1;
                    start      = 1'b1;
                    state_next = bus.eop_in ? FLUSH : PACK;
                end
            end
            PACK: begin
                if (accept) begin
                    wr = 1'b1;
                    if (bus.eop_in) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (final_c) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Returning from FLUSH holds ready low one extra cycle before reopening.
    assign ready_next = ((state == IDLE) && (state_next == IDLE)) ||
                        ((state_next == PACK) && (cnt_next_c <= CNT_W'(RDY_MAX)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.ready_out <= 1'b1;
        end else begin
            state         <= state_next;
            bus.ready_out <= ready_next;
        end
    end

`ifdef DATA_PACK_ERR_EN
    logic err_next;

    assign err_next = accept && (((state == IDLE) && !bus.sop_in) ||
                                 ((state == PACK) && bus.sop_in));

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.err_out <= 1'b0;
        end else begin
            bus.err_out <= err_next;
        end
    end
`endif

    data_pack_datapath u_datapath (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .start      (start),
        .flush      (flush),
        .ready_in   (bus.ready_in),
        .data_in    (bus.data_in),
        .valid_out  (bus.valid_out),
        .data_out   (bus.data_out),
        .sop_out    (bus.sop_out),
        .eop_out    (bus.eop_out),
        .cnt_next_c (cnt_next_c),
        .final_c    (final_c)
    );

endmodule

// File: tb/tb_data_pack.sv
// Scoreboard bench for data_pack: a bit-queue packet model predicts words, a monitor compares them.
module tb_data_pack;
    import data_pack_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_pack_if bus();

    data_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   bits_q[$];
    bit   in_pkt = 1'b0;
    bit   first_pending = 1'b0;
    logic exp_err = 1'b0;
    int   rdy_mode = 0;
    int   stall_cycles = 0;
    int   words_seen = 0;
    int   eop_seen = 0;
    logic [31:0] last_data = '0;
    logic        last_sop = 1'b0;
    logic        last_eop = 1'b0;
    logic [31:0] sop_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Take up to 32 bits from the front of the packet bit stream as one word.
    function automatic void emit_word(input bit eop);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            if (bits_q.size() > 0) w[i] = bits_q.pop_front();
        end
        exp_q.push_back('{w, first_pending, eop});
        first_pending = 1'b0;
    endfunction

    function automatic void model_accept(input logic [6:0] d, input logic s, input logic e);
        exp_err = (!in_pkt && !s) || (in_pkt && s);
        if (!in_pkt) begin
            if (!s) return;
            in_pkt        = 1'b1;
            first_pending = 1'b1;
            bits_q.delete();
        end
        for (int i = 0; i < 7; i++) bits_q.push_back(d[i]);
        if (e) begin
            while (bits_q.size() > 32) emit_word(1'b0);
            emit_word(1'b1);
            in_pkt = 1'b0;
        end else begin
            while (bits_q.size() >= 32) emit_word(1'b0);
        end
    endfunction

    // Monitor and model observer, sampling mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            bits_q.delete();
            in_pkt  = 1'b0;
            exp_err = 1'b0;
        end else begin
`ifdef DATA_PACK_ERR_EN
            check("err_out", 32'(bus.err_out), 32'(exp_err));
`endif
            exp_err = 1'b0;
            if (bus.valid_out && bus.ready_in) begin
                words_seen++;
                last_data = bus.data_out;
                last_sop  = bus.sop_out;
                last_eop  = bus.eop_out;
                if (bus.sop_out) sop_word = bus.data_out;
                if (bus.eop_out) eop_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", bus.data_out);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("data_out", bus.data_out, x.data);
                    check("sop_out", 32'(bus.sop_out), 32'(x.sop));
                    check("eop_out", 32'(bus.eop_out), 32'(x.eop));
                end
            end
            if (bus.valid_in && bus.ready_out)
                model_accept(bus.data_in, bus.sop_in, bus.eop_in);
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.ready_in = 1'b1;
            1:       bus.ready_in = ($urandom_range(0, 3) != 0);
            default: bus.ready_in = 1'b0;
        endcase
    end

    task automatic send(input logic [6:0] d, input logic s, input logic e);
        int n;
        n = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.sop_in   = s;
        bus.eop_in   = e;
        forever begin
            @(negedge clk);
            if (bus.ready_out) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got ready_out=0 for %0d cycles required 1", n);
                break;
            end
        end
        stall_cycles += n;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        idle(4);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, e0, s0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.sop_in   = 1'b0;
        bus.eop_in   = 1'b0;
        bus.ready_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_ready_out", 32'(bus.ready_out), 32'd1);
        check("rst_data_out", bus.data_out, 32'd0);

        // Mixed values, first word framed with sop.
        send(7'h5A, 1'b1, 1'b0);
        send(7'h00, 1'b0, 1'b0);
        send(7'h33, 1'b0, 1'b0);
        send(7'h00, 1'b0, 1'b0);
        send(7'h7F, 1'b0, 1'b0);
        for (int i = 0; i < 27; i++) send(7'($urandom), 1'b0, i == 26);
        drain();
        check("t1_first_word", sop_word, 32'hF00C_C05A);

        // Full-rate all-ones packet: 224 bits, seven words, no input stall.
        idle(5);
        w0 = words_seen; e0 = eop_seen; s0 = stall_cycles;
        for (int i = 0; i < 32; i++) send(7'h7F, i == 0, i == 31);
        drain();
        check("t2_words", 32'(words_seen - w0), 32'd7);
        check("t2_eops", 32'(eop_seen - e0), 32'd1);
        check("t2_last_word", last_data, 32'hFFFF_FFFF);
        check("t2_last_eop", 32'(last_eop), 32'd1);
        check("t2_stalls", 32'(stall_cycles - s0), 32'd0);

        // 35-bit packet: full word then zero-filled tail.
        w0 = words_seen;
        for (int i = 0; i < 5; i++) send(7'h7F, i == 0, i == 4);
        drain();
        check("t3_words", 32'(words_seen - w0), 32'd2);
        check("t3_tail", last_data, 32'h0000_0007);
        check("t3_tail_eop", 32'(last_eop), 32'd1);

        // Single-value packet.
        send(7'h55, 1'b1, 1'b1);
        drain();
        check("t4_word", last_data, 32'h0000_0055);
        check("t4_sop", 32'(last_sop), 32'd1);
        check("t4_eop", 32'(last_eop), 32'd1);
        check("t4_ready_idle", 32'(bus.ready_out), 32'd1);

        // Downstream stall mid-stream fills the accumulator and blocks input.
        for (int i = 0; i < 8; i++) send(7'($urandom), i == 0, 1'b0);
        rdy_mode = 2;
        fork
            begin
                for (int i = 0; i < 12; i++) send(7'($urandom), 1'b0, i == 11);
            end
            begin
                repeat (10) @(posedge clk);
                #2;
                check("t5_ready_stalled", 32'(bus.ready_out), 32'd0);
                rdy_mode = 0;
            end
        join
        drain();
        w0 = words_seen;
        send(7'h11, 1'b0, 1'b0);
        send(7'h22, 1'b0, 1'b1);
        send(7'h33, 1'b0, 1'b0);
        drain();
        check("t5_junk_words", 32'(words_seen - w0), 32'd0);

        // Reset with a word held in the output register.
        rdy_mode = 2;
        idle(2);
        for (int i = 0; i < 6; i++) send(7'($urandom), i == 0, 1'b0);
        idle(2);
        check("t6_held_valid", 32'(bus.valid_out), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_valid_out", 32'(bus.valid_out), 32'd0);
        check("t6_sop_out", 32'(bus.sop_out), 32'd0);
        check("t6_eop_out", 32'(bus.eop_out), 32'd0);
        check("t6_data_out", bus.data_out, 32'd0);
        check("t6_ready_out", 32'(bus.ready_out), 32'd1);
`ifdef DATA_PACK_ERR_EN
        check("t6_err_out", 32'(bus.err_out), 32'd0);
`endif
        rdy_mode = 0;
        send(7'h01, 1'b1, 1'b0);
        send(7'h02, 1'b0, 1'b0);
        send(7'h03, 1'b0, 1'b1);
        drain();
        check("t6_repack", last_data, 32'h0000_C101);

        // Random packets, junk, stray sop and random downstream backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int len;
            if ($urandom_range(0, 4) == 0) send(7'($urandom), 1'b0, 1'($urandom));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                send(7'($urandom), (i == 0) || ($urandom_range(0, 9) == 0), i == len - 1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        drain();
        rdy_mode = 0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
